comp16_seq: RTL

Sequential 16-bit magnitude comparator for the ALU16 compare path. It time-shares a single `comp4` 4-bit comparator slice across the operand nibbles, most-significant nibble first. It supports unsigned and two's-complement comparison, terminates early on the first unequal nibble, and reports the result through a start/done handshake. It sits between the ALU16 control unit and the flag logic, giving compare results without four parallel slices.

---
 rtl/comp_pkg.sv | 33 +++
 rtl/comp16_seq_if.sv | 27 ++
 rtl/comp4.sv | 14 +
 rtl/comp16_seq.sv | 130 +++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the sequential nibble comparator: state encoding,
// nibble width and the result code consumed by the ALU16 flag logic.
package comp_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    // Result code; RES_NONE marks an empty first-difference register.
    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_LT   = 2'd1,
        RES_EQ   = 2'd2,
        RES_GT   = 2'd3
    } res_t;

    // Expand a result code into the {lt, eq, gt} flag triple.
    function automatic logic [2:0] res_flags(input res_t r);
        logic [2:0] f;
        f = 3'b000;
        case (r)
            RES_LT:  f = 3'b100;
            RES_EQ:  f = 3'b010;
            RES_GT:  f = 3'b001;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/comp16_seq_if.sv
// Compare request/result bundle between the ALU16 control unit (master)
// and the sequential comparator (slave).
//   start, signed_mode, a, b : request, sampled while the comparator is idle
//   busy, done, lt, eq, gt   : status and registered result flags
interface comp16_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, lt, eq, gt
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, lt, eq, gt
    );
endinterface

// File: rtl/comp4.sv
// Combinational 4-bit unsigned magnitude comparator slice.
//   a, b       : 4-bit operands
//   eq, gt, lt : a == b, a > b, a < b
module comp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);
    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);
endmodule

// File: rtl/comp16_seq.sv
// Sequential WIDTH-bit magnitude comparator that time-shares one comp4 slice
// across the operand nibbles, most-significant nibble first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of comp16_seq_if (start/signed_mode/a/b in,
//                busy/done/lt/eq/gt out, all outputs registered)
module comp16_seq
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    comp16_seq_if.slave   bus
);

    localparam int unsigned NIBS  = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDX_W-1:0] idx;
    res_t             sticky;
    logic             busy_q;
    logic             done_q;
    logic             lt_q;
    logic             eq_q;
    logic             gt_q;

    logic [NIB_W-1:0] nib_a_c;
    logic [NIB_W-1:0] nib_b_c;
    logic             slice_eq_c;
    logic             slice_gt_c;
    logic             slice_lt_c;
    logic             decide_c;
    res_t             final_c;

    // Operand nibble mux selected by the running index.
    always_comb begin
        nib_a_c = '0;
        nib_b_c = '0;
        for (int unsigned i = 0; i < NIBS; i++) begin
            if (IDX_W'(i) == idx) begin
                nib_a_c = op_a[i*NIB_W +: NIB_W];
                nib_b_c = op_b[i*NIB_W +: NIB_W];
            end
        end
    end

    comp4 u_comp4 (
        .a  (nib_a_c),
        .b  (nib_b_c),
        .eq (slice_eq_c),
        .gt (slice_gt_c),
        .lt (slice_lt_c)
    );

    // Decide whether this cycle finishes the compare and with which result;
    // an earlier recorded difference always outranks the current slice.
    always_comb begin
        decide_c = 1'b0;
        final_c  = RES_EQ;
        if (state == ST_CMP) begin
            if (!slice_eq_c && (EARLY_EXIT || idx == '0)) begin
                decide_c = 1'b1;
                if (sticky != RES_NONE) begin
                    final_c = sticky;
                end else begin
                    final_c = slice_gt_c ? RES_GT : RES_LT;
                end
            end else if (slice_eq_c && idx == '0) begin
                decide_c = 1'b1;
                final_c  = (sticky != RES_NONE) ? sticky : RES_EQ;
            end
        end
    end

    // FSM, index counter, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            idx    <= '0;
            sticky <= RES_NONE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
            gt_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        // Flipping the sign bits maps two's-complement order onto unsigned order.
                        op_a   <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
                        op_b   <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
                        idx    <= IDX_W'(NIBS - 1);
                        sticky <= RES_NONE;
                        busy_q <= 1'b1;
                        state  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (decide_c) begin
                        {lt_q, eq_q, gt_q} <= res_flags(final_c);
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        if (!slice_eq_c && sticky == RES_NONE) begin
                            sticky <= slice_gt_c ? RES_GT : RES_LT;
                        end
                        idx <= idx - IDX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.lt   = lt_q;
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;

endmodule
